tfu_pwl_loader: RTL and testbench
=================================

Name: tfu_pwl_loader

Overview:
- Writer side of the tanh transfer-function unit's piecewise-linear coefficient tables.
- Accepts a stream of {slope, intercept} words and writes them into the inactive bank of the double-banked slope/intercept RAMs.
- On a complete, well-formed load it swaps the active bank when the tanh datapath signals a safe point. The tanh evaluators keep reading the active bank undisturbed while a new table is loaded.

Parameters:
- ADDR_W, 8, table address width; table depth N = 2**ADDR_W entries (indexed by x[14:7]).
- SLOPE_W, 8, slope field width.
- ICPT_W, 15, intercept field width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a table load
- abort  in  1  one-cycle pulse: cancel the load in progress
- s_valid  in  1  coefficient word valid
- s_ready  out  1  loader accepts a word
- s_data  in  SLOPE_W+ICPT_W  {slope, intercept}; slope in the MSBs
- s_last  in  1  marks the final word of a table
- commit_ok  in  1  tanh pipeline quiescent; bank swap permitted
- wr_en  out  1  table RAM write strobe
- wr_bank  out  1  bank being written (always ~active_bank)
- wr_addr  out  ADDR_W  table write address
- wr_slope  out  SLOPE_W  slope write data
- wr_intercept  out  ICPT_W  intercept write data
- active_bank  out  1  bank the tanh units read (MSB of their LUT address)
- busy  out  1  high in LOAD or COMMIT
- done  out  1  one-cycle pulse when a swap takes effect
- error  out  1  sticky malformed-load flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; s_ready=0, wr_en=0, wr_addr=0, wr_slope=0, wr_intercept=0, active_bank=0, wr_bank=1, busy=0, done=0, error=0.
- States are IDLE, LOAD, COMMIT, ERR. busy=1 in LOAD and COMMIT.
- IDLE or ERR, start=1:
  - Next state LOAD; address counter cleared to 0; error cleared; s_ready=1 from the next cycle.
  - start in LOAD or COMMIT is ignored.
- LOAD handshake:
  - A beat is accepted when s_valid & s_ready.
  - The accepted beat is registered: wr_en=1 exactly one cycle later, with wr_addr = counter at acceptance and wr_slope/wr_intercept = s_data fields.
  - The counter then increments. Back-to-back beats give one write per cycle.
- LOAD exits:
  - Beat with s_last=1 at counter==N-1: beat is written; next state COMMIT; s_ready=0.
  - Beat with s_last=1 at counter<N-1 (short table): beat is written; next state ERR; error=1.
  - Beat with s_last=0 at counter==N-1 (long table): beat is written; next state ERR; error=1.
  - The counter never wraps.
- abort in LOAD: next state IDLE, s_ready=0, no swap, error unchanged.
  - If abort coincides with a handshake, the beat is consumed and discarded (no wr_en).
  - abort in COMMIT also returns to IDLE without a swap. abort in IDLE or ERR has no effect.
- COMMIT: waits for commit_ok=1, then toggles active_bank, pulses done for one cycle, and returns to IDLE.
  - wr_bank follows ~active_bank the same cycle.
  - If commit_ok is already high on entry, the swap occurs on the first COMMIT cycle.
- ERR: s_ready=0, active_bank unchanged, error held until the next start.
- Partially written inactive-bank contents are don't-care; they are never exposed because no swap occurs.
- Write-to-visibility latency: last beat accepted at cycle t -> wr_en at t+1 -> COMMIT from t+1 -> earliest active_bank toggle at t+2.
- No arithmetic; fields are passed through unmodified and unsigned.

Decomposition:
- Shared package tfu_pkg holds:
  - TFU_ADDR_W=8, TFU_SLOPE_W=8, TFU_ICPT_W=15
  - the loader state enum
  - the coefficient word field offsets, shared with tfu_tanh's LUT interface.
- Single module; no sub-module is warranted. The FSM, counter and write register are all small.

Test Plan:
- Full load: start, 256 beats with slope=addr[7:0], intercept=addr*3, s_last on beat 255, commit_ok=1 -> 256 wr_en pulses at addr 0..255 on bank 1; active_bank 0->1 at t+2; done one cycle; error=0.
- Throttled source and commit hold: s_valid toggled every other cycle, commit_ok=0 for 10 cycles after the last beat -> busy=1 throughout; swap and done occur on the first cycle commit_ok=1.
- Short table: s_last on beat 99 -> 100 writes (addr 0..99), state ERR, error=1, active_bank unchanged; a subsequent start clears error.
- Long table: 256 beats with no s_last -> error=1 after the beat at addr 255, no swap, s_ready=0.
- Abort at beat 50 coincident with a handshake -> no write for beat 50, IDLE next cycle, active_bank unchanged; a new full load then swaps normally.
- Reset mid-load at beat 128 -> all outputs at reset values immediately (async), active_bank=0.

Source files
------------

// File: rtl/tfu_pkg.sv
// Shared definitions for the tanh transfer-function unit: table geometry,
// coefficient word layout and the PWL loader state encoding.
package tfu_pkg;

    localparam int unsigned TFU_ADDR_W  = 8;
    localparam int unsigned TFU_SLOPE_W = 8;
    localparam int unsigned TFU_ICPT_W  = 15;

    // Coefficient word is {slope, intercept}; tfu_tanh's LUT uses the same layout.
    localparam int unsigned TFU_WORD_W    = TFU_SLOPE_W + TFU_ICPT_W;
    localparam int unsigned TFU_ICPT_LSB  = 0;
    localparam int unsigned TFU_SLOPE_LSB = TFU_ICPT_W;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit,
        StErr
    } loader_state_e;

endpackage

// File: rtl/tfu_pwl_loader.sv
// Writes a streamed {slope, intercept} table into the inactive bank of the
// double-banked PWL RAMs and swaps banks at a pipeline-safe point.
module tfu_pwl_loader
    import tfu_pkg::*;
#(
    parameter int unsigned ADDR_W  = TFU_ADDR_W,
    parameter int unsigned SLOPE_W = TFU_SLOPE_W,
    parameter int unsigned ICPT_W  = TFU_ICPT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SLOPE_W+ICPT_W-1:0] s_data,
    input  logic                      s_last,
    input  logic                      commit_ok,
    output logic                      wr_en,
    output logic                      wr_bank,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [SLOPE_W-1:0]        wr_slope,
    output logic [ICPT_W-1:0]         wr_intercept,
    output logic                      active_bank,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam logic [ADDR_W-1:0] LastAddr = '1;

    loader_state_e state_q, state_d;

    logic [ADDR_W-1:0]  cnt_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [SLOPE_W-1:0] wr_slope_q;
    logic [ICPT_W-1:0]  wr_icpt_q;
    logic               active_bank_q;
    logic               done_q;
    logic               error_q;

    logic start_go;
    logic accept;
    logic write_beat;
    logic tbl_end;
    logic bad_load;
    logic swap;

    assign start_go   = start && ((state_q == StIdle) || (state_q == StErr));
    assign accept     = s_valid && s_ready;
    // A beat accepted together with abort is consumed but never written.
    assign write_beat = accept && !abort;
    assign tbl_end    = (cnt_q == LastAddr);
    assign bad_load   = write_beat && (s_last != tbl_end);
    assign swap       = (state_q == StCommit) && commit_ok && !abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (accept) begin
                    if (s_last && tbl_end)      state_d = StCommit;
                    else if (s_last || tbl_end) state_d = StErr;
                end
            end
            StCommit: begin
                if (abort || commit_ok) state_d = StIdle;
            end
            StErr: begin
                if (start) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready = (state_q == StLoad);
        busy    = (state_q == StLoad) || (state_q == StCommit);
    end

    // Address counter, write register, bank and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_slope_q    <= '0;
            wr_icpt_q     <= '0;
            active_bank_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            wr_en_q <= write_beat;
            done_q  <= swap;

            if (start_go) begin
                cnt_q <= '0;
            end else if (accept && !tbl_end) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end

            if (write_beat) begin
                wr_addr_q  <= cnt_q;
                wr_slope_q <= s_data[ICPT_W +: SLOPE_W];
                wr_icpt_q  <= s_data[ICPT_W-1:0];
            end

            if (start_go) begin
                error_q <= 1'b0;
            end else if (bad_load) begin
                error_q <= 1'b1;
            end

            if (swap) active_bank_q <= ~active_bank_q;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_slope     = wr_slope_q;
    assign wr_intercept = wr_icpt_q;
    assign active_bank  = active_bank_q;
    assign wr_bank      = ~active_bank_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_tfu_pwl_loader.sv
// Directed bench for tfu_pwl_loader: expected table writes are queued as beats
// are driven and matched against every wr_en pulse.
module tb_tfu_pwl_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned SW = 8;
    localparam int unsigned IW = 15;
    localparam int unsigned N  = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [SW+IW-1:0]  s_data = '0;
    logic              s_last = 1'b0;
    logic              commit_ok = 1'b0;
    logic              wr_en;
    logic              wr_bank;
    logic [AW-1:0]     wr_addr;
    logic [SW-1:0]     wr_slope;
    logic [IW-1:0]     wr_intercept;
    logic              active_bank;
    logic              busy;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;
    int nwr    = 0;
    logic [31:0] exp_q[$];

    tfu_pwl_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .commit_ok    (commit_ok),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_slope     (wr_slope),
        .wr_intercept (wr_intercept),
        .active_bank  (active_bank),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns after the edge and retire any table write.
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            nwr++;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {wr_bank, wr_addr, wr_slope, wr_intercept}, 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                chk("wr_beat", {wr_bank, wr_addr, wr_slope, wr_intercept}, e);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive one beat (held until accepted in the next edge); queue its write.
    task automatic beat(input int i, input logic last, input logic bank, input logic alt);
        logic [SW-1:0] sl;
        logic [IW-1:0] ic;
        sl = alt ? ~SW'(i) : SW'(i);
        ic = alt ? IW'(i * 5) : IW'(i * 3);
        s_valid = 1'b1;
        s_data  = {sl, ic};
        s_last  = last;
        exp_q.push_back({bank, AW'(i), sl, ic});
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", {22'd0, s_ready, wr_en, wr_bank, active_bank, busy, done, error, 3'd0},
            {22'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        chk("rst_wdata", {1'b0, wr_addr, wr_slope, wr_intercept}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full load, commit_ok already high
        commit_ok = 1'b1;
        pulse_start();
        chk("full_ready", {31'd0, s_ready}, 32'd1);
        chk("full_busy", {31'd0, busy}, 32'd1);
        nwr = 0;
        for (int i = 0; i < int'(N); i++) beat(i, i == int'(N) - 1, 1'b1, 1'b0);
        chk("full_nwr", nwr, N);
        chk("full_commit_state", {active_bank, s_ready, busy, done}, 4'b0010);
        tick();
        chk("full_swap", {active_bank, wr_bank, busy, done, error}, 5'b10010);
        tick();
        chk("full_done_pulse", {31'd0, done}, 32'd0);
        chk("full_q", exp_q.size(), 0);

        // Throttled source, commit held off
        commit_ok = 1'b0;
        pulse_start();
        nwr = 0;
        for (int i = 0; i < int'(N); i++) begin
            beat(i, i == int'(N) - 1, 1'b0, 1'b1);
            tick();
            if (i % 64 == 0) chk("thr_busy", {31'd0, busy}, 32'd1);
        end
        chk("thr_nwr", nwr, N);
        for (int k = 0; k < 10; k++) tick();
        chk("thr_hold", {active_bank, busy, done, s_ready}, 4'b1100);
        commit_ok = 1'b1;
        tick();
        chk("thr_swap", {active_bank, busy, done}, 3'b001);
        tick();
        chk("thr_done_pulse", {31'd0, done}, 32'd0);
        chk("thr_q", exp_q.size(), 0);

        // Short table: last on beat 99
        pulse_start();
        nwr = 0;
        for (int i = 0; i < 100; i++) beat(i, i == 99, 1'b1, 1'b0);
        chk("short_nwr", nwr, 100);
        chk("short_err", {error, busy, s_ready, active_bank}, 4'b1000);
        tick();
        tick();
        chk("short_noswap", {active_bank, done}, 2'b00);
        pulse_start();
        chk("short_restart", {error, busy, s_ready}, 3'b011);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {busy, s_ready}, 2'b00);

        // Long table: no s_last at all
        pulse_start();
        nwr = 0;
        for (int i = 0; i < int'(N); i++) beat(i, 1'b0, 1'b1, 1'b1);
        chk("long_nwr", nwr, N);
        chk("long_err", {error, s_ready, busy}, 3'b100);
        for (int k = 0; k < 4; k++) tick();
        chk("long_noswap", {active_bank, done, error}, 3'b001);
        chk("long_q", exp_q.size(), 0);

        // Abort coincident with beat 50
        pulse_start();
        chk("abort_errclr", {31'd0, error}, 32'd0);
        for (int i = 0; i < 50; i++) beat(i, 1'b0, 1'b1, 1'b0);
        s_valid = 1'b1;
        s_data  = '1;
        abort   = 1'b1;
        tick();
        s_valid = 1'b0;
        abort   = 1'b0;
        chk("abort_state", {busy, s_ready, active_bank, error}, 4'b0000);
        tick();
        tick();
        chk("abort_q", exp_q.size(), 0);
        pulse_start();
        for (int i = 0; i < int'(N); i++) beat(i, i == int'(N) - 1, 1'b1, 1'b1);
        tick();
        chk("reload_swap", {active_bank, done, error}, 3'b110);
        chk("reload_q", exp_q.size(), 0);

        // Reset mid-load at beat 128
        pulse_start();
        for (int i = 0; i < 128; i++) beat(i, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_outs", {s_ready, wr_en, wr_bank, active_bank, busy, done, error},
            7'b0010000);
        chk("mrst_wdata", {1'b0, wr_addr, wr_slope, wr_intercept}, 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_idle", {busy, active_bank, s_ready}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
